// File: rtl/crc_pkg.sv
// Shared types, standard CRC presets and the bit-reflection helper for the streaming CRC engine.
package crc_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic [5:0]  width;
        logic [31:0] poly;
        logic [31:0] init;
        logic        refin;
        logic        refout;
        logic [31:0] xorout;
    } crc_cfg_t;

    localparam crc_cfg_t CRC8 = '{width: 6'd8, poly: 32'h0000_0007, init: 32'h0000_0000,
                                  refin: 1'b0, refout: 1'b0, xorout: 32'h0000_0000};
    localparam crc_cfg_t CRC16_CCITT = '{width: 6'd16, poly: 32'h0000_1021, init: 32'h0000_FFFF,
                                         refin: 1'b0, refout: 1'b0, xorout: 32'h0000_0000};
    localparam crc_cfg_t CRC32 = '{width: 6'd32, poly: 32'h04C1_1DB7, init: 32'hFFFF_FFFF,
                                   refin: 1'b1, refout: 1'b1, xorout: 32'hFFFF_FFFF};

    // Mirrors the low 'width' bits; bits above 'width' come back as zero.
    function automatic logic [31:0] reflect_bits(input logic [31:0] value, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) r[i] = value[width-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_stream_engine_byte_step.sv
// Combinational one-byte CRC update, bit-serial definition unrolled over the eight bits.
module crc_byte_step
    import crc_pkg::*;
#(
    parameter int             CRC_W = 8,
    parameter logic [CRC_W-1:0] POLY = CRC_W'(8'h07),
    parameter bit             REFIN = 1'b0
) (
    input  logic [CRC_W-1:0] crc_i,
    input  logic [7:0]       byte_i,
    output logic [CRC_W-1:0] crc_o
);

    logic [CRC_W-1:0] crc_v;
    logic             bit_v;
    logic             fb_v;

    always_comb begin
        crc_v = crc_i;
        bit_v = 1'b0;
        fb_v  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bit_v = REFIN ? byte_i[k] : byte_i[7-k];
            fb_v  = crc_v[CRC_W-1] ^ bit_v;
            crc_v = (crc_v << 1) ^ (fb_v ? POLY : '0);
        end
        crc_o = crc_v;
    end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: DATA_W/8 byte steps per beat, valid/ready on input and result sides.
//   state | meaning
//   IDLE  | no frame open
//   BUSY  | frame open, crc_q holds the running CRC
module crc_stream_engine
    import crc_pkg::*;
#(
    parameter int               CRC_W  = 8,
    parameter int               DATA_W = 8,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(8'h07),
    parameter logic [CRC_W-1:0] INIT   = '0,
    parameter bit               REFIN  = 1'b0,
    parameter bit               REFOUT = 1'b0,
    parameter logic [CRC_W-1:0] XOROUT = '0,
    localparam int              LANES  = DATA_W / 8,
    localparam int              NB_W   = $clog2(LANES) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_sof_i,
    input  logic              in_last_i,
    input  logic [NB_W-1:0]   in_nbytes_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CRC_W-1:0]  out_crc_o,
    output logic              out_abort_o
);

    state_e           state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic             out_valid_q, out_valid_d;
    logic [CRC_W-1:0] out_crc_q, out_crc_d;
    logic             out_abort_q, out_abort_d;

    logic [CRC_W-1:0] seed;
    logic [CRC_W-1:0] next_crc;
    logic [CRC_W-1:0] chain [LANES+1];
    logic             accept;

    assign seed     = (in_sof_i || state_q == ST_IDLE) ? INIT : crc_q;
    assign chain[0] = seed;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        crc_byte_step #(
            .CRC_W (CRC_W),
            .POLY  (POLY),
            .REFIN (REFIN)
        ) u_step (
            .crc_i  (chain[g]),
            .byte_i (in_data_i[8*g +: 8]),
            .crc_o  (chain[g+1])
        );
    end

    // Out-of-range lane counts fall through to the full-beat tap.
    always_comb begin
        next_crc = chain[LANES];
        if (in_last_i) begin
            for (int i = 1; i <= LANES; i++) begin
                if (in_nbytes_i == NB_W'(i)) next_crc = chain[i];
            end
        end
    end

    assign in_ready_o = !clr_i && (!out_valid_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        out_valid_d = out_valid_q;
        out_crc_d   = out_crc_q;
        out_abort_d = 1'b0;
        if (out_valid_q && out_ready_i) out_valid_d = 1'b0;
        if (clr_i) begin
            crc_d   = INIT;
            state_d = ST_IDLE;
        end else if (accept) begin
            if (in_sof_i && state_q == ST_BUSY) out_abort_d = 1'b1;
            if (in_last_i) begin
                out_crc_d   = (REFOUT ? CRC_W'(reflect_bits(32'(next_crc), CRC_W)) : next_crc) ^ XOROUT;
                out_valid_d = 1'b1;
                crc_d       = INIT;
                state_d     = ST_IDLE;
            end else begin
                crc_d   = next_crc;
                state_d = ST_BUSY;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            crc_q       <= INIT;
            out_valid_q <= 1'b0;
            out_crc_q   <= '0;
            out_abort_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            out_valid_q <= out_valid_d;
            out_crc_q   <= out_crc_d;
            out_abort_q <= out_abort_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_crc_o   = out_crc_q;
    assign out_abort_o = out_abort_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Scoreboard bench for crc_stream_engine: CRC-8 / 8-bit, CRC-16-CCITT / 16-bit and CRC-32 / 32-bit instances.
module tb_crc_stream_engine;
    import crc_pkg::*;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst, clr, in_valid, in_sof, in_last, out_ready;
    logic [63:0] in_data;
    logic [3:0]  in_nbytes;
    int          sel;

    logic        v8, v16, v32;
    logic        in_ready8, out_valid8, out_abort8;
    logic        in_ready16, out_valid16, out_abort16;
    logic        in_ready32, out_valid32, out_abort32;
    logic [7:0]  out_crc8;
    logic [15:0] out_crc16;
    logic [31:0] out_crc32;

    logic        in_ready_m, out_valid_m, out_abort_m;
    logic [31:0] out_crc_m;

    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          abort_cnt = 0;

    always #5 clk = ~clk;

    assign v8  = in_valid && (sel == 0);
    assign v16 = in_valid && (sel == 1);
    assign v32 = in_valid && (sel == 2);

    crc_stream_engine #(
        .CRC_W(8), .DATA_W(8), .POLY(CRC8.poly[7:0]), .INIT(CRC8.init[7:0]),
        .REFIN(CRC8.refin), .REFOUT(CRC8.refout), .XOROUT(CRC8.xorout[7:0])
    ) u_dut8 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .in_valid_i(v8), .in_ready_o(in_ready8),
        .in_data_i(in_data[7:0]), .in_sof_i(in_sof), .in_last_i(in_last), .in_nbytes_i(in_nbytes[0:0]),
        .out_valid_o(out_valid8), .out_ready_i(out_ready), .out_crc_o(out_crc8), .out_abort_o(out_abort8)
    );

    crc_stream_engine #(
        .CRC_W(16), .DATA_W(16), .POLY(CRC16_CCITT.poly[15:0]), .INIT(CRC16_CCITT.init[15:0]),
        .REFIN(CRC16_CCITT.refin), .REFOUT(CRC16_CCITT.refout), .XOROUT(CRC16_CCITT.xorout[15:0])
    ) u_dut16 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .in_valid_i(v16), .in_ready_o(in_ready16),
        .in_data_i(in_data[15:0]), .in_sof_i(in_sof), .in_last_i(in_last), .in_nbytes_i(in_nbytes[1:0]),
        .out_valid_o(out_valid16), .out_ready_i(out_ready), .out_crc_o(out_crc16), .out_abort_o(out_abort16)
    );

    crc_stream_engine #(
        .CRC_W(32), .DATA_W(32), .POLY(CRC32.poly), .INIT(CRC32.init),
        .REFIN(CRC32.refin), .REFOUT(CRC32.refout), .XOROUT(CRC32.xorout)
    ) u_dut32 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .in_valid_i(v32), .in_ready_o(in_ready32),
        .in_data_i(in_data[31:0]), .in_sof_i(in_sof), .in_last_i(in_last), .in_nbytes_i(in_nbytes[2:0]),
        .out_valid_o(out_valid32), .out_ready_i(out_ready), .out_crc_o(out_crc32), .out_abort_o(out_abort32)
    );

    always_comb begin
        in_ready_m  = in_ready8;
        out_valid_m = out_valid8;
        out_abort_m = out_abort8;
        out_crc_m   = {24'h0, out_crc8};
        if (sel == 1) begin
            in_ready_m  = in_ready16;
            out_valid_m = out_valid16;
            out_abort_m = out_abort16;
            out_crc_m   = {16'h0, out_crc16};
        end else if (sel == 2) begin
            in_ready_m  = in_ready32;
            out_valid_m = out_valid32;
            out_abort_m = out_abort32;
            out_crc_m   = out_crc32;
        end
    end

    // Result side: a transfer happens at the next rising edge whenever valid and ready are both high here.
    always @(negedge clk) begin
        if (!rst && out_valid_m === 1'b1 && out_ready === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_result sel=%0d got=%h expected=none", sel, out_crc_m);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (out_crc_m !== e) begin
                    n_err++;
                    $display("FAIL sb_crc sel=%0d got=%h expected=%h", sel, out_crc_m, e);
                end
            end
        end
        if (out_abort_m === 1'b1) abort_cnt++;
    end

    function automatic logic [31:0] model(input byte_q_t d, input int s);
        int w;
        logic [31:0] poly, crc, xo, mask, r;
        logic ri, ro, bt, fb;
        case (s)
            0:       begin w = 8;  poly = 32'h07;       crc = 32'h0;        ri = 0; ro = 0; xo = 32'h0; end
            1:       begin w = 16; poly = 32'h1021;     crc = 32'hFFFF;     ri = 0; ro = 0; xo = 32'h0; end
            default: begin w = 32; poly = 32'h04C11DB7; crc = 32'hFFFFFFFF; ri = 1; ro = 1; xo = 32'hFFFFFFFF; end
        endcase
        mask = (w == 32) ? 32'hFFFFFFFF : ((32'd1 << w) - 32'd1);
        foreach (d[i]) begin
            for (int k = 0; k < 8; k++) begin
                bt  = ri ? d[i][k] : d[i][7-k];
                fb  = crc[w-1] ^ bt;
                crc = ((crc << 1) ^ (fb ? poly : 32'h0)) & mask;
            end
        end
        if (ro) begin
            r = 32'h0;
            for (int j = 0; j < w; j++) r[j] = crc[w-1-j];
            crc = r;
        end
        return (crc ^ xo) & mask;
    endfunction

    function automatic byte_q_t str2q(input string s);
        byte_q_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic byte_q_t rand_q(input int n);
        byte_q_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    task automatic put_beat(input logic [63:0] d, input logic [3:0] nb, input logic sof, input logic last);
        int t;
        t = 0;
        @(negedge clk);
        in_data = d; in_nbytes = nb; in_sof = sof; in_last = last; in_valid = 1'b1;
        #1;
        while (in_ready_m !== 1'b1) begin
            t++;
            if (t > 200) begin
                n_cmp++; n_err++;
                $display("FAIL in_ready_timeout sel=%0d got=%b expected=1", sel, in_ready_m);
                break;
            end
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_sof = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_frame(input byte_q_t data, input logic sof, input logic closes, input logic [31:0] exp);
        int lanes, nbeats, idx;
        logic [63:0] d;
        lanes  = (sel == 0) ? 1 : (sel == 1) ? 2 : 4;
        nbeats = (data.size() + lanes - 1) / lanes;
        if (closes) exp_q.push_back(exp);
        for (int b = 0; b < nbeats; b++) begin
            d = 64'h0;
            for (int l = 0; l < lanes; l++) begin
                idx = b * lanes + l;
                if (idx < data.size()) d[8*l +: 8] = data[idx];
            end
            if (b == nbeats - 1)
                put_beat(d, 4'(data.size() - b * lanes), sof && b == 0, closes);
            else
                put_beat(d, 4'(lanes), sof && b == 0, 1'b0);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0) begin
            t++;
            if (t > 200) begin
                n_cmp++; n_err++;
                $display("FAIL drain_timeout sel=%0d got=%0d expected=0 pending", sel, exp_q.size());
                exp_q.delete();
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_last = 1'b0;
        in_data = 64'h0; in_nbytes = 4'h0; out_ready = 1'b1; sel = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            n_cmp++; if (in_ready_m !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready sel=%0d got=%b expected=1", s, in_ready_m); end
            n_cmp++; if (out_valid_m !== 1'b0) begin n_err++; $display("FAIL reset_out_valid sel=%0d got=%b expected=0", s, out_valid_m); end
            n_cmp++; if (out_crc_m !== 32'h0)  begin n_err++; $display("FAIL reset_out_crc sel=%0d got=%h expected=0", s, out_crc_m); end
            n_cmp++; if (out_abort_m !== 1'b0) begin n_err++; $display("FAIL reset_out_abort sel=%0d got=%b expected=0", s, out_abort_m); end
        end
        sel = 0;
    endtask

    task automatic test_crc8();
        byte_q_t q;
        sel = 0;
        send_frame(str2q("123456789"), 1'b1, 1'b1, 32'hF4);
        @(negedge clk);
        n_cmp++; if (out_valid_m !== 1'b1) begin n_err++; $display("FAIL crc8_latency got=%b expected=1", out_valid_m); end
        q = {8'h01};
        send_frame(q, 1'b1, 1'b1, 32'h07);
        for (int f = 0; f < 5; f++) begin
            q = rand_q($urandom_range(1, 6));
            send_frame(q, 1'b1, 1'b1, model(q, 0));
        end
        wait_drain();
        n_cmp++; if (abort_cnt !== 0) begin n_err++; $display("FAIL crc8_no_abort got=%0d expected=0", abort_cnt); end
    endtask

    task automatic test_crc32();
        byte_q_t q;
        sel = 2;
        send_frame(str2q("123456789"), 1'b1, 1'b1, 32'hCBF43926);
        for (int f = 0; f < 6; f++) begin
            q = rand_q($urandom_range(1, 12));
            send_frame(q, 1'b1, 1'b1, model(q, 2));
        end
        // Out-of-range in_nbytes on the last beat count as a full beat.
        q = rand_q(8);
        exp_q.push_back(model(q, 2));
        put_beat({32'h0, q[3], q[2], q[1], q[0]}, 4'd4, 1'b1, 1'b0);
        put_beat({32'h0, q[7], q[6], q[5], q[4]}, 4'd0, 1'b0, 1'b1);
        q = rand_q(4);
        exp_q.push_back(model(q, 2));
        put_beat({32'h0, q[3], q[2], q[1], q[0]}, 4'd5, 1'b1, 1'b1);
        wait_drain();
    endtask

    task automatic test_crc16_stall();
        byte_q_t q;
        sel = 1;
        @(posedge clk); #1 out_ready = 1'b0;
        send_frame(str2q("123456789"), 1'b1, 1'b1, 32'h29B1);
        @(negedge clk);
        in_data = {48'h0, 8'h32, 8'h31}; in_nbytes = 4'd2; in_sof = 1'b1; in_last = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++; if (in_ready_m !== 1'b0)      begin n_err++; $display("FAIL stall_in_ready cyc=%0d got=%b expected=0", c, in_ready_m); end
            n_cmp++; if (out_valid_m !== 1'b1)     begin n_err++; $display("FAIL stall_out_valid cyc=%0d got=%b expected=1", c, out_valid_m); end
            n_cmp++; if (out_crc_m !== 32'h29B1)   begin n_err++; $display("FAIL stall_out_crc cyc=%0d got=%h expected=29b1", c, out_crc_m); end
            @(negedge clk);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
        q = str2q("ABCDEFG");
        send_frame(q, 1'b1, 1'b1, model(q, 1));
        q = rand_q(4);
        send_frame(q, 1'b1, 1'b1, model(q, 1));
        wait_drain();
    endtask

    task automatic test_abort();
        sel = 0;
        abort_cnt = 0;
        send_frame(str2q("1234"), 1'b1, 1'b0, 32'h0);
        send_frame(str2q("123456789"), 1'b1, 1'b1, 32'hF4);
        wait_drain();
        n_cmp++; if (abort_cnt !== 1) begin n_err++; $display("FAIL abort_pulses got=%0d expected=1", abort_cnt); end
    endtask

    task automatic test_rst_midframe();
        sel = 0;
        send_frame(str2q("1234"), 1'b1, 1'b0, 32'h0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        #1;
        n_cmp++; if (out_valid_m !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b expected=0", out_valid_m); end
        send_frame(str2q("123456789"), 1'b0, 1'b1, 32'hF4);
        wait_drain();
    endtask

    task automatic test_clr();
        sel = 0;
        send_frame(str2q("1234"), 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        clr = 1'b1; in_valid = 1'b1; in_data = 64'hAA; in_sof = 1'b1; in_last = 1'b1; in_nbytes = 4'd1;
        #1;
        n_cmp++; if (in_ready_m !== 1'b0) begin n_err++; $display("FAIL clr_in_ready got=%b expected=0", in_ready_m); end
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_last = 1'b0;
        send_frame(str2q("123456789"), 1'b0, 1'b1, 32'hF4);
        wait_drain();
        @(posedge clk); #1 out_ready = 1'b0;
        send_frame(str2q("123456789"), 1'b1, 1'b1, 32'hF4);
        @(negedge clk) clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (out_valid_m !== 1'b1) begin n_err++; $display("FAIL clr_pending_valid got=%b expected=1", out_valid_m); end
        n_cmp++; if (out_crc_m !== 32'hF4) begin n_err++; $display("FAIL clr_pending_crc got=%h expected=f4", out_crc_m); end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_crc8();
        test_crc32();
        test_crc16_stall();
        test_abort();
        test_rst_midframe();
        test_clr();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/crc_stream_engine.md
Name: crc_stream_engine

Overview:
- Parametrised streaming CRC engine that replaces the fixed CRC-8 (poly 0x07), 8-bit-per-cycle calculator.
- Supports configurable CRC width, polynomial, init, reflection and final XOR.
- Handles multi-byte data beats, with a partial last beat.
- Uses valid/ready framing on both input and result sides.
- Sits between packet datapaths and framers/checkers; one frame's CRC is produced per in_last beat.

Parameters:
- CRC_W, 8, CRC width in bits (1..32)
- DATA_W, 8, input beat width; multiple of 8, 8..64
- POLY, 8'h07, generator polynomial, normal (MSB-first) form, implicit x^CRC_W term
- INIT, 0, CRC register value at frame start
- REFIN, 0, 1 = reflect each input byte before processing
- REFOUT, 0, 1 = reflect the final CRC before XOROUT
- XOROUT, 0, value XORed into the final CRC

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- clr  in  1  synchronous frame abort; reloads INIT and drops any unfinished frame
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  DATA_W  beat data; byte lane 0 = in_data[7:0], processed first
- in_sof  in  1  first beat of a frame; forces start from INIT
- in_last  in  1  last beat of a frame
- in_nbytes  in  $clog2(DATA_W/8)+1  valid lanes on the last beat (1..DATA_W/8); ignored unless in_last
- out_valid  out  1  result valid
- out_ready  in  1  result consumer ready
- out_crc  out  CRC_W  final CRC of the frame
- out_abort  out  1  one-cycle pulse: in_sof seen mid-frame, partial frame discarded

Behaviour:
- Reset values: crc_q=INIT, state=IDLE, out_valid=0, out_crc=0, out_abort=0. in_ready=1 once rst is released.
- States:
  - IDLE: no frame open.
  - BUSY: frame open, crc_q holds the running CRC.
- Transitions on an accepted beat:
  - IDLE -> BUSY on any beat without in_last. A first beat without in_sof is still treated as a frame start from INIT.
  - BUSY -> IDLE on in_last.
  - IDLE + in_last (single-beat frame) stays IDLE.
- Per accepted beat: next = step(seed, lanes), where:
  - seed = INIT if (in_sof or state==IDLE), else crc_q.
  - lanes = DATA_W/8, or in_nbytes on an in_last beat.
  - Bytes are processed lane 0 first.
  - Within a byte, processing is MSB first, or LSB first when REFIN=1.
- Bitwise definition of step for each input bit b: fb = crc[CRC_W-1]^b; crc = (crc<<1) ^ (fb ? POLY : 0). Unrolled fully combinationally.
- Non-last beat: crc_q <= next.
- Last beat:
  - out_crc <= (REFOUT ? reflect(next) : next) ^ XOROUT.
  - out_valid <= 1 on the following edge, so latency is one cycle.
  - crc_q <= INIT.
- Result handshake:
  - out_valid and out_crc are held stable until out_valid && out_ready.
  - in_ready = !out_valid || out_ready. The engine never overwrites an unconsumed result, and back-to-back frames run at full rate when out_ready=1.
- in_sof while BUSY:
  - The partial CRC is dropped and the beat is processed from INIT.
  - out_abort pulses the cycle after acceptance.
- in_nbytes out of range (0 or > DATA_W/8) on an in_last beat is treated as DATA_W/8.
- clr:
  - crc_q <= INIT, state <= IDLE.
  - A pending out_valid result is NOT cleared.
  - An input beat presented in the same cycle is ignored (in_ready is forced to 0 while clr=1).
- rst mid-frame: everything returns to reset values immediately, and any partial result is lost.

Decomposition:
- Package crc_pkg:
  - function reflect_bits(value, width).
  - A localparam set of named presets: CRC8 (0x07), CRC16_CCITT (0x1021/FFFF), CRC32 (04C11DB7, refl, FFFFFFFF/FFFFFFFF).
- Sub-module crc_byte_step: combinational single-byte update. Parameters CRC_W, POLY, REFIN. Inputs crc_in and byte; output crc_out.
- The top instantiates DATA_W/8 chained crc_byte_step instances and muxes the chain tap selected by in_nbytes.

Test Plan:
- Defaults, one frame, ASCII "123456789" as nine 1-byte beats (sof on first, last on ninth) -> out_crc=8'hF4 one cycle after the last beat. Single beat 8'h01 with sof+last -> 8'h07.
- CRC_W=32, DATA_W=32, POLY=32'h04C11DB7, INIT=XOROUT=32'hFFFFFFFF, REFIN=REFOUT=1, "123456789" as beats 0x34333231, 0x38373635, then last beat 0x00000039 with in_nbytes=1 -> out_crc=32'hCBF43926.
- CRC16_CCITT preset (0x1021, INIT=FFFF), DATA_W=16, "123456789" in 5 beats (last nbytes=1) -> 16'h29B1. Hold out_ready=0 for 4 cycles and present a second frame meanwhile -> in_ready=0 and out_crc stable. Second result follows after release.
- Defaults: "1234" then in_sof with "123456789" without an intervening last -> out_abort pulses once, and the final out_crc=8'hF4.
- Assert rst for 1 cycle mid-frame after "1234", then send "123456789" -> 8'hF4. Repeat using clr instead of rst -> same result, and a pending out_valid survives the clr.
